// File: rtl/femto_soc.sv
// femto_soc: memory-mapped I/O for the femto RV32 core.
//  - 0x800000.. : read-only SPI-flash window (command 0x03), stalls the core via mem_rbusy
//  - 0x400004   : LEDS (5 bits)
//  - 0x400008   : UART data (write = send, read = received byte)
//  - 0x400010   : UART control/status (bit8 rx_valid, bit9 tx_busy)
// Build option: define FEMTO_UART_RX_EN to include the UART receiver; without it RXD is
// ignored and rx_valid/rx_byte read as 0.
module femto_soc #(
    parameter int unsigned CLK_FREQ_HZ = 25000000,
    parameter int unsigned BAUD_RATE   = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        spi_cs_n,
    output logic        spi_clk,
    output logic        spi_mosi,
    input  logic        spi_miso,
    input  logic        RXD,
    output logic        TXD,
    output logic [4:0]  LEDS
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam logic [15:0] BitLast      = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HalfLast     = 16'(CLKS_PER_BIT / 2 - 1);
    // 64 SCK periods of 2 clk, plus one trailing low cycle before DONE
    localparam logic [7:0]  ShiftLast    = 8'd128;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic sel_flash, sel_io, sel_leds, sel_dat, sel_cntl;
    logic flash_idle, wr_en, rd_en;

    assign sel_flash = mem_addr[23];
    assign sel_io    = ~mem_addr[23] & mem_addr[22];
    assign sel_leds  = sel_io & (mem_addr[4:2] == 3'b001);
    assign sel_dat   = sel_io & (mem_addr[4:2] == 3'b010);
    assign sel_cntl  = sel_io & (mem_addr[4:2] == 3'b100);

    // All bus traffic is ignored while a flash read is stalling the core
    assign wr_en = (mem_wmask != 4'b0000) & flash_idle;
    assign rd_en = mem_rstrb & flash_idle;

    // ------------------------------------------------------------------
    // Flash read FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } flash_st_e;

    flash_st_e   fl_st_q, fl_st_d;
    logic [7:0]  fl_cnt_q, fl_cnt_d;
    logic        fl_sck_q, fl_sck_d;
    logic [31:0] fl_tx_q, fl_tx_d;
    logic [31:0] fl_rx_q, fl_rx_d;
    logic        fl_cs_n_q, fl_cs_n_d;
    logic        fl_busy_q, fl_busy_d;

    assign flash_idle = (fl_st_q == StIdle);

    // Flash FSM next state: command/address out on SCK fall, data in on SCK rise
    always_comb begin
        fl_st_d   = fl_st_q;
        fl_cnt_d  = fl_cnt_q;
        fl_sck_d  = fl_sck_q;
        fl_tx_d   = fl_tx_q;
        fl_rx_d   = fl_rx_q;
        fl_cs_n_d = fl_cs_n_q;
        fl_busy_d = fl_busy_q;
        unique case (fl_st_q)
            StIdle: begin
                if (mem_rstrb && sel_flash) begin
                    fl_st_d   = StShift;
                    fl_cnt_d  = 8'd0;
                    fl_sck_d  = 1'b0;
                    fl_tx_d   = {8'h03, 1'b0, mem_addr[22:2], 2'b00};
                    fl_cs_n_d = 1'b0;
                    fl_busy_d = 1'b1;
                end
            end
            StShift: begin
                fl_cnt_d = fl_cnt_q + 8'd1;
                if (fl_cnt_q == ShiftLast) begin
                    fl_st_d = StDone;
                end else begin
                    fl_sck_d = ~fl_sck_q;
                    if (!fl_sck_q) begin
                        // SCK rising: the last 32 samples are the data bytes
                        fl_rx_d = {fl_rx_q[30:0], spi_miso};
                    end else begin
                        // SCK falling: present next MOSI bit while SCK is low
                        fl_tx_d = {fl_tx_q[30:0], 1'b0};
                    end
                end
            end
            StDone: begin
                fl_st_d   = StIdle;
                fl_cs_n_d = 1'b1;
                fl_busy_d = 1'b0;
            end
            default: fl_st_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // LED register and UART transmitter
    // ------------------------------------------------------------------
    logic [4:0]  leds_q, leds_d;
    logic        tx_busy_q, tx_busy_d;
    logic        txd_q, txd_d;
    logic [8:0]  tx_sh_q, tx_sh_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;

    // LED write (byte 0 only) and TX bit timing; tx_bit counts start(0)..stop(9)
    always_comb begin
        leds_d    = leds_q;
        tx_busy_d = tx_busy_q;
        txd_d     = txd_q;
        tx_sh_d   = tx_sh_q;
        tx_bit_d  = tx_bit_q;
        tx_cnt_d  = tx_cnt_q;
        if (wr_en && sel_leds && mem_wmask[0]) begin
            leds_d = mem_wdata[4:0];
        end
        if (!tx_busy_q) begin
            if (wr_en && sel_dat) begin
                tx_busy_d = 1'b1;
                txd_d     = 1'b0;
                tx_sh_d   = {1'b1, mem_wdata[7:0]};
                tx_bit_d  = 4'd0;
                tx_cnt_d  = 16'd0;
            end
        end else if (tx_cnt_q == BitLast) begin
            tx_cnt_d = 16'd0;
            if (tx_bit_q == 4'd9) begin
                tx_busy_d = 1'b0;
            end else begin
                txd_d    = tx_sh_q[0];
                tx_sh_d  = {1'b1, tx_sh_q[8:1]};
                tx_bit_d = tx_bit_q + 4'd1;
            end
        end else begin
            tx_cnt_d = tx_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    logic       rx_valid;
    logic [7:0] rx_byte;

`ifdef FEMTO_UART_RX_EN
    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } rx_st_e;

    rx_st_e      rx_st_q, rx_st_d;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;

    assign rx_valid = rx_valid_q;
    assign rx_byte  = rx_byte_q;

    // RX FSM next state; a completing byte is assigned last so it beats a clearing read
    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        if (rd_en && sel_dat) begin
            rx_valid_d = 1'b0;
        end
        unique case (rx_st_q)
            RxIdle: begin
                if (rx_s3_q && !rx_s2_q) begin
                    rx_st_d  = RxStart;
                    rx_cnt_d = 16'd0;
                end
            end
            RxStart: begin
                if (rx_cnt_q == HalfLast) begin
                    // Re-check mid start bit so a glitch does not start a frame
                    rx_cnt_d = 16'd0;
                    rx_bit_d = 3'd0;
                    rx_st_d  = rx_s2_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxData: begin
                if (rx_cnt_q == BitLast) begin
                    rx_cnt_d = 16'd0;
                    rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_st_d = RxStop;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == BitLast) begin
                    rx_st_d = RxIdle;
                    if (rx_s2_q) begin
                        rx_byte_d  = rx_sh_q;
                        rx_valid_d = 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_st_d = RxIdle;
        endcase
    end

    // RX registers, including the RXD synchroniser and edge-detect stage
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_st_q    <= RxIdle;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'd0;
            rx_byte_q  <= 8'd0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_s1_q    <= RXD;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
        end
    end
`else
    assign rx_valid = 1'b0;
    assign rx_byte  = 8'd0;
`endif

    // ------------------------------------------------------------------
    // Read data
    // ------------------------------------------------------------------
    logic [31:0] rdata_q, rdata_d;

    // Read mux: flash result lands in DONE, I/O reads the cycle after the strobe
    always_comb begin
        rdata_d = rdata_q;
        if (fl_st_q == StDone) begin
            // First byte received is the lowest-addressed byte
            rdata_d = {fl_rx_q[7:0], fl_rx_q[15:8], fl_rx_q[23:16], fl_rx_q[31:24]};
        end else if (rd_en && !sel_flash) begin
            rdata_d = 32'd0;
            if (sel_leds) begin
                rdata_d = {27'd0, leds_q};
            end
            if (sel_dat) begin
                rdata_d = {24'd0, rx_byte};
            end
            if (sel_cntl) begin
                rdata_d = {22'd0, tx_busy_q, rx_valid, 8'd0};
            end
        end
    end

    // Main state registers; synchronous reset aborts any transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            fl_st_q   <= StIdle;
            fl_cnt_q  <= 8'd0;
            fl_sck_q  <= 1'b0;
            fl_tx_q   <= 32'd0;
            fl_rx_q   <= 32'd0;
            fl_cs_n_q <= 1'b1;
            fl_busy_q <= 1'b0;
            leds_q    <= 5'd0;
            tx_busy_q <= 1'b0;
            txd_q     <= 1'b1;
            tx_sh_q   <= 9'd0;
            tx_bit_q  <= 4'd0;
            tx_cnt_q  <= 16'd0;
            rdata_q   <= 32'd0;
        end else begin
            fl_st_q   <= fl_st_d;
            fl_cnt_q  <= fl_cnt_d;
            fl_sck_q  <= fl_sck_d;
            fl_tx_q   <= fl_tx_d;
            fl_rx_q   <= fl_rx_d;
            fl_cs_n_q <= fl_cs_n_d;
            fl_busy_q <= fl_busy_d;
            leds_q    <= leds_d;
            tx_busy_q <= tx_busy_d;
            txd_q     <= txd_d;
            tx_sh_q   <= tx_sh_d;
            tx_bit_q  <= tx_bit_d;
            tx_cnt_q  <= tx_cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_rbusy = fl_busy_q;
    assign spi_cs_n  = fl_cs_n_q;
    assign spi_clk   = fl_sck_q;
    assign spi_mosi  = fl_tx_q[31];
    assign TXD       = txd_q;
    assign LEDS      = leds_q;

endmodule

// File: tb/tb_femto_soc.sv
// Self-checking bench for femto_soc: table-driven I/O register vectors plus
// hand-written UART TX/RX, flash read and mid-transfer reset sequences.
module tb_femto_soc;

    localparam int BIT_CLKS = 217;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        spi_cs_n, spi_clk, spi_mosi;
    logic        spi_miso;
    logic        RXD;
    logic        TXD;
    logic [4:0]  LEDS;

    int checks = 0;
    int errors = 0;

    femto_soc dut (
        .clk       (clk),
        .reset     (reset),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .mem_rbusy (mem_rbusy),
        .spi_cs_n  (spi_cs_n),
        .spi_clk   (spi_clk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .RXD       (RXD),
        .TXD       (TXD),
        .LEDS      (LEDS)
    );

    always #5 clk = ~clk;

    // ---------------- SPI flash model (mode 0, command 0x03) ----------------
    logic [7:0]  fmem [0:255];
    logic [31:0] fcmd  = 32'd0;
    int          fbits = 0;
    logic        sck_prev = 1'b0;

    always @(spi_clk, spi_cs_n) begin
        if (spi_cs_n) begin
            fbits = 0;
        end else if (spi_clk && !sck_prev) begin
            if (fbits < 32) fcmd = {fcmd[30:0], spi_mosi};
            fbits = fbits + 1;
        end else if (!spi_clk && sck_prev) begin
            if (fbits >= 32 && fbits < 64) begin
                int idx;
                logic [7:0] a;
                logic [7:0] b;
                idx = fbits - 32;
                a = fcmd[7:0] + 8'(idx / 8);
                b = fmem[a];
                spi_miso = b[7 - (idx % 8)];
            end
        end
        sck_prev = spi_clk;
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [23:0] a, input logic [31:0] d, input logic [3:0] m);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = m;
        @(negedge clk);
        mem_wmask = 4'h0;
    endtask

    task automatic bus_read(input logic [23:0] a, output logic [31:0] d);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        d = mem_rdata;
    endtask

    task automatic uart_drive(input logic [7:0] b, input logic stop);
        RXD = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RXD = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        RXD = stop;
        repeat (BIT_CLKS) @(negedge clk);
        RXD = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Flash read with busy-length, data, command and (optionally) ignored-write checks
    task automatic flash_read(input logic [23:0] a, input logic [31:0] exp,
                              input logic [31:0] exp_cmd, input logic [4:0] exp_leds,
                              input bit poke);
        int n;
        mem_addr  = a;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        chk("flash_cs_low", {31'd0, spi_cs_n}, 32'd0);
        n = 0;
        while (mem_rbusy && n < 500) begin
            if (poke && n == 10) begin
                mem_addr  = 24'h400004;
                mem_wdata = 32'h1F;
                mem_wmask = 4'h1;
            end else begin
                mem_wmask = 4'h0;
            end
            n++;
            @(negedge clk);
        end
        mem_wmask = 4'h0;
        chk("flash_busy_cycles", 32'(n), 32'd130);
        chk("flash_rdata", mem_rdata, exp);
        chk("flash_cs_high", {31'd0, spi_cs_n}, 32'd1);
        chk("flash_mosi_cmd", fcmd, exp_cmd);
        chk("flash_leds_kept", {27'd0, LEDS}, {27'd0, exp_leds});
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        wr;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] exp_rdata;
        logic [4:0]  exp_leds;
    } vec_t;

    vec_t vecs [15];

    initial begin
        logic [31:0] d;
        logic [9:0]  frame;

        for (int i = 0; i < 256; i++) fmem[i] = 8'(i);
        fmem[8'h10] = 8'hEF;
        fmem[8'h11] = 8'hBE;
        fmem[8'h12] = 8'hAD;
        fmem[8'h13] = 8'hDE;

        vecs[0]  = '{1'b0, 24'h400004, 32'h0,        4'h0, 32'h0,  5'h00};
        vecs[1]  = '{1'b1, 24'h400004, 32'h15,       4'h1, 32'h0,  5'h15};
        vecs[2]  = '{1'b0, 24'h400004, 32'h0,        4'h0, 32'h15, 5'h15};
        vecs[3]  = '{1'b0, 24'h400000, 32'h0,        4'h0, 32'h0,  5'h15};
        vecs[4]  = '{1'b1, 24'h400004, 32'h0A,       4'h2, 32'h0,  5'h15};
        vecs[5]  = '{1'b1, 24'h400004, 32'hFFFFFFEA, 4'hF, 32'h0,  5'h0A};
        vecs[6]  = '{1'b0, 24'h400004, 32'h0,        4'h0, 32'h0A, 5'h0A};
        vecs[7]  = '{1'b1, 24'h000004, 32'h1F,       4'hF, 32'h0,  5'h0A};
        vecs[8]  = '{1'b1, 24'h200004, 32'h1F,       4'hF, 32'h0,  5'h0A};
        vecs[9]  = '{1'b0, 24'h400010, 32'h0,        4'h0, 32'h0,  5'h0A};
        vecs[10] = '{1'b0, 24'h400004, 32'h0,        4'h0, 32'h0A, 5'h0A};
        vecs[11] = '{1'b0, 24'h000004, 32'h0,        4'h0, 32'h0,  5'h0A};
        vecs[12] = '{1'b0, 24'h400008, 32'h0,        4'h0, 32'h0,  5'h0A};
        vecs[13] = '{1'b1, 24'h400004, 32'h15,       4'h1, 32'h0,  5'h15};
        vecs[14] = '{1'b0, 24'h400004, 32'h0,        4'h0, 32'h15, 5'h15};

        reset     = 1'b1;
        mem_addr  = 24'h0;
        mem_wdata = 32'h0;
        mem_wmask = 4'h0;
        mem_rstrb = 1'b0;
        RXD       = 1'b1;
        spi_miso  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_leds",  {27'd0, LEDS}, 32'd0);
        chk("rst_txd",   {31'd0, TXD}, 32'd1);
        chk("rst_cs_n",  {31'd0, spi_cs_n}, 32'd1);
        chk("rst_sck",   {31'd0, spi_clk}, 32'd0);
        chk("rst_mosi",  {31'd0, spi_mosi}, 32'd0);
        chk("rst_rbusy", {31'd0, mem_rbusy}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Register vectors
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) begin
                bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].wmask);
            end else begin
                bus_read(vecs[i].addr, d);
                chk("vec_rdata", d, vecs[i].exp_rdata);
                chk("vec_rbusy", {31'd0, mem_rbusy}, 32'd0);
            end
            chk("vec_leds", {27'd0, LEDS}, {27'd0, vecs[i].exp_leds});
        end

        // UART TX of 0x41, with a dropped write during the frame
        frame = {1'b1, 8'h41, 1'b0};
        bus_write(24'h400008, 32'h41, 4'h1);
        bus_read(24'h400010, d);
        chk("tx_cntl_busy", d, 32'h200);
        bus_write(24'h400008, 32'hFF, 4'h1);
        repeat (BIT_CLKS / 2 - 2) @(negedge clk);
        chk("tx_start_bit", {31'd0, TXD}, 32'd0);
        for (int i = 1; i < 10; i++) begin
            repeat (BIT_CLKS) @(negedge clk);
            chk("tx_bit", {31'd0, TXD}, {31'd0, frame[i]});
        end
        repeat (BIT_CLKS - BIT_CLKS / 2) @(negedge clk);
        bus_read(24'h400010, d);
        chk("tx_cntl_idle", d, 32'h0);
        chk("tx_line_idle", {31'd0, TXD}, 32'd1);

        // UART RX
`ifdef FEMTO_UART_RX_EN
        uart_drive(8'h34, 1'b1);
        bus_read(24'h400010, d);
        chk("rx_cntl_valid", d, 32'h100);
        bus_read(24'h400008, d);
        chk("rx_dat", d, 32'h34);
        bus_read(24'h400010, d);
        chk("rx_cntl_cleared", d, 32'h0);
        uart_drive(8'h5A, 1'b0);
        bus_read(24'h400010, d);
        chk("rx_frame_err_cntl", d, 32'h0);
        bus_read(24'h400008, d);
        chk("rx_frame_err_dat", d, 32'h34);
        uart_drive(8'h11, 1'b1);
        uart_drive(8'h22, 1'b1);
        bus_read(24'h400010, d);
        chk("rx_overrun_cntl", d, 32'h100);
        bus_read(24'h400008, d);
        chk("rx_overrun_dat", d, 32'h22);
`else
        uart_drive(8'h34, 1'b1);
        bus_read(24'h400010, d);
        chk("rx_off_cntl", d, 32'h0);
        bus_read(24'h400008, d);
        chk("rx_off_dat", d, 32'h0);
`endif

        // Flash read of 0x000010, LED write during the stall is dropped
        flash_read(24'h800010, 32'hDEADBEEF, 32'h03000010, 5'h15, 1'b1);
        chk("flash_mosi_idle", {31'd0, spi_mosi}, 32'd0);

        // Reset in the middle of a flash read
        mem_addr  = 24'h800010;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        repeat (50) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_cs_n",  {31'd0, spi_cs_n}, 32'd1);
        chk("midrst_rbusy", {31'd0, mem_rbusy}, 32'd0);
        chk("midrst_sck",   {31'd0, spi_clk}, 32'd0);
        chk("midrst_leds",  {27'd0, LEDS}, 32'd0);
        chk("midrst_rdata", mem_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        flash_read(24'h800014, 32'h17161514, 32'h03000014, 5'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
